plab5_mcore_debug_multi_interface: RTL and testbench

PLAB5_MCORE_DEBUG_MULTI_INTERFACE -- requirements
Module: plab5_mcore_debug_multi_interface

---
 rtl/plab5_mcore_debug_pkg.sv | 20 ++
 rtl/plab5_mcore_debug_rr_arb.sv | 45 ++++
 rtl/vc_EnResetReg.sv | 18 +
 rtl/plab5_mcore_debug_multi_interface.sv | 145 ++++++++++++++
 tb/tb_plab5_mcore_debug_multi_interface.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plab5_mcore_debug_pkg.sv
// Shared encodings for the multi-channel debug interface: FSM states, op codes
// and the default per-phase wait limit.
package plab5_mcore_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DBG_REQ  = 3'd1,
    ST_DBG_WAIT = 3'd2,
    ST_EXT_REQ  = 3'd3,
    ST_EXT_WAIT = 3'd4,
    ST_RESULT   = 3'd5
  } state_e;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_READ = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/plab5_mcore_debug_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when advance is strobed.
module plab5_mcore_debug_rr_arb #(
  parameter int p_num_ch = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [p_num_ch-1:0] req,
  input  logic                advance,
  output logic [p_num_ch-1:0] grant
);

  localparam int W = $clog2(p_num_ch);

  logic [W-1:0] ptr_q, ptr_d, win;
  logic         found;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < p_num_ch; i++) begin
      idx = (int'(ptr_q) + i) % p_num_ch;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found)
      ptr_d = (win == W'(p_num_ch - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_EnResetReg.sv
// Enabled register with synchronous active-high reset to a fixed value.
module vc_EnResetReg #(
  parameter int               p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [p_nbits-1:0] q,
  input  logic [p_nbits-1:0] d,
  input  logic               en
);

  always_ff @(posedge clk) begin
    if (reset)   q <= p_reset_value;
    else if (en) q <= d;
  end

endmodule

// File: rtl/plab5_mcore_debug_multi_interface.sv
// Multi-channel debug front end: arbitrates requesters, runs the optional debug
// request phase and the extract phase against memory, and returns one result.
module plab5_mcore_debug_multi_interface
  import plab5_mcore_debug_pkg::*;
#(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_num_ch     = 4,
  parameter int p_timeout    = DEFAULT_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_ch-1:0]              req_val,
  output logic [p_num_ch-1:0]              req_rdy,
  input  logic [p_num_ch-1:0]              req_op,
  input  logic [p_num_ch*p_addr_nbits-1:0] req_src_addr,
  input  logic [p_num_ch*p_addr_nbits-1:0] req_dest_addr,
  input  logic [p_num_ch-1:0]              req_domain,
  output logic                             start,
  output logic                             inst,
  output logic [p_addr_nbits-1:0]         src_addr,
  output logic [p_addr_nbits-1:0]         dest_addr,
  output logic                             domain,
  input  logic                             ack,
  input  logic [p_data_nbits-1:0]         read_data,
  input  logic                             resp_domain,
  output logic                             result_val,
  output logic [p_data_nbits-1:0]         result_data,
  output logic [$clog2(p_num_ch)-1:0]     result_ch,
  output logic                             result_err,
  input  logic                             result_rdy
);

  localparam int                 CH_W     = $clog2(p_num_ch);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(p_timeout - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [p_num_ch-1:0]     grant;
  logic [CH_W-1:0]         ch_d, ch_q;
  logic                    op_d, op_q, dom_d, dom_q;
  logic [p_addr_nbits-1:0] src_d, src_q, dest_d, dest_q;
  logic [p_data_nbits-1:0] res_data_d, res_data_q;
  logic                    res_err_d, res_err_q, res_en;
  logic                    hs, ack_ok, tmo;

  plab5_mcore_debug_rr_arb #(.p_num_ch(p_num_ch)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_val),
    .advance (hs),
    .grant   (grant)
  );

  assign req_rdy = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign hs      = |(req_val & req_rdy);

  always_comb begin
    ch_d = '0;
    for (int i = 0; i < p_num_ch; i++)
      if (grant[i]) ch_d = CH_W'(i);
  end

  assign op_d   = req_op[ch_d];
  assign dom_d  = req_domain[ch_d];
  assign src_d  = req_src_addr[int'(ch_d)*p_addr_nbits +: p_addr_nbits];
  assign dest_d = req_dest_addr[int'(ch_d)*p_addr_nbits +: p_addr_nbits];

  vc_EnResetReg #(.p_nbits(1))            op_reg   (.clk(clk), .reset(reset), .q(op_q),   .d(op_d),   .en(hs));
  vc_EnResetReg #(.p_nbits(1))            dom_reg  (.clk(clk), .reset(reset), .q(dom_q),  .d(dom_d),  .en(hs));
  vc_EnResetReg #(.p_nbits(CH_W))         ch_reg   (.clk(clk), .reset(reset), .q(ch_q),   .d(ch_d),   .en(hs));
  vc_EnResetReg #(.p_nbits(p_addr_nbits)) src_reg  (.clk(clk), .reset(reset), .q(src_q),  .d(src_d),  .en(hs));
  vc_EnResetReg #(.p_nbits(p_addr_nbits)) dest_reg (.clk(clk), .reset(reset), .q(dest_q), .d(dest_d), .en(hs));
  vc_EnResetReg #(.p_nbits(p_data_nbits)) rdat_reg (.clk(clk), .reset(reset), .q(res_data_q), .d(res_data_d), .en(res_en));
  vc_EnResetReg #(.p_nbits(1))            rerr_reg (.clk(clk), .reset(reset), .q(res_err_q),  .d(res_err_d),  .en(res_en));

  // Responses from the other security domain are invisible; an ack beats timeout.
  assign ack_ok = ack && (resp_domain == dom_q);
  assign tmo    = !ack_ok && (cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_en     = 1'b0;
    res_err_d  = 1'b0;
    res_data_d = '0;
    case (state_q)
      ST_IDLE:     if (hs) state_d = (op_d == OP_READ) ? ST_EXT_REQ : ST_DBG_REQ;
      ST_DBG_REQ:  begin cnt_d = '0; state_d = ST_DBG_WAIT; end
      ST_EXT_REQ:  begin cnt_d = '0; state_d = ST_EXT_WAIT; end
      ST_DBG_WAIT: begin
        if (ack_ok)   state_d = ST_EXT_REQ;
        else if (tmo) begin state_d = ST_RESULT; res_en = 1'b1; res_err_d = 1'b1; end
        else          cnt_d = cnt_q + 1'b1;
      end
      ST_EXT_WAIT: begin
        if (ack_ok)   begin state_d = ST_RESULT; res_en = 1'b1; res_data_d = read_data; end
        else if (tmo) begin state_d = ST_RESULT; res_en = 1'b1; res_err_d = 1'b1; end
        else          cnt_d = cnt_q + 1'b1;
      end
      ST_RESULT:   if (result_rdy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Addresses stay on the bus through each wait phase and are zero elsewhere.
  always_comb begin
    start     = 1'b0;
    inst      = 1'b0;
    src_addr  = '0;
    dest_addr = '0;
    case (state_q)
      ST_DBG_REQ, ST_DBG_WAIT: begin
        start     = (state_q == ST_DBG_REQ);
        src_addr  = src_q;
        dest_addr = dest_q;
      end
      ST_EXT_REQ, ST_EXT_WAIT: begin
        start     = (state_q == ST_EXT_REQ);
        inst      = 1'b1;
        src_addr  = (op_q == OP_COPY) ? dest_q : src_q;
        dest_addr = dest_q;
      end
      default: ;
    endcase
    if (reset) start = 1'b0;
  end

  assign domain      = dom_q;
  assign result_val  = (state_q == ST_RESULT) && !reset;
  assign result_data = res_data_q;
  assign result_ch   = ch_q;
  assign result_err  = res_err_q;

endmodule

// File: tb/tb_plab5_mcore_debug_multi_interface.sv
// Scoreboard bench for the multi-channel debug interface: directed requests push
// expected grants, memory starts and results; a monitor pops and compares them.
module tb_plab5_mcore_debug_multi_interface;

  localparam int AW = 32, DW = 32, NCH = 4, CW = 2, TMO = 5;
  localparam logic COPY = 1'b0, READ = 1'b1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     req_val, req_rdy, req_op, req_domain;
  logic [NCH*AW-1:0]  req_src_addr, req_dest_addr;
  logic               start, inst, domain, ack, resp_domain;
  logic [AW-1:0]      src_addr, dest_addr;
  logic [DW-1:0]      read_data, result_data;
  logic               result_val, result_err, result_rdy;
  logic [CW-1:0]      result_ch;

  plab5_mcore_debug_multi_interface #(
    .p_addr_nbits(AW), .p_data_nbits(DW), .p_num_ch(NCH), .p_timeout(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
    .req_src_addr(req_src_addr), .req_dest_addr(req_dest_addr), .req_domain(req_domain),
    .start(start), .inst(inst), .src_addr(src_addr), .dest_addr(dest_addr), .domain(domain),
    .ack(ack), .read_data(read_data), .resp_domain(resp_domain),
    .result_val(result_val), .result_data(result_data), .result_ch(result_ch),
    .result_err(result_err), .result_rdy(result_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic inst; logic [AW-1:0] src; logic [AW-1:0] dest; logic dom; } st_t;
  typedef struct packed { logic [CW-1:0] ch; logic [DW-1:0] data; logic err; } rs_t;

  st_t st_q[$];
  rs_t rs_q[$];
  int  gr_q[$];
  st_t se;
  rs_t re;
  int  ge;
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (|(req_val & req_rdy)) begin
        if (gr_q.size() == 0) bad("grant_unexpected");
        else begin
          ge = gr_q.pop_front();
          chk("grant_onehot", 64'(req_rdy), 64'(4'b0001 << ge));
        end
      end
      if (start) begin
        if (st_q.size() == 0) bad("start_unexpected");
        else begin
          se = st_q.pop_front();
          chk("start_inst", 64'(inst), 64'(se.inst));
          chk("start_src", 64'(src_addr), 64'(se.src));
          chk("start_dom", 64'(domain), 64'(se.dom));
          if (!se.inst) chk("start_dest", 64'(dest_addr), 64'(se.dest));
        end
      end
      if (result_val && result_rdy) begin
        if (rs_q.size() == 0) bad("result_unexpected");
        else begin
          re = rs_q.pop_front();
          chk("result_ch", 64'(result_ch), 64'(re.ch));
          chk("result_data", 64'(result_data), 64'(re.data));
          chk("result_err", 64'(result_err), 64'(re.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ch, input logic op, input logic [AW-1:0] src,
                       input logic [AW-1:0] dest, input logic dom);
    bit done;
    done = 1'b0;
    req_op[ch] = op;
    req_src_addr[ch*AW +: AW]  = src;
    req_dest_addr[ch*AW +: AW] = dest;
    req_domain[ch] = dom;
    req_val[ch] = 1'b1;
    gr_q.push_back(ch);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_rdy[ch]) begin
        tick();
        req_val[ch] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      bad("issue_no_grant");
      req_val[ch] = 1'b0;
    end
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1'b1;
    end
    if (!seen) bad(name);
  endtask

  // Returns the number of non-result cycles observed before result_val.
  task automatic wait_result(input string name, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (result_val) seen = 1'b1;
      else n++;
    end
    if (!seen) bad(name);
  endtask

  // Called at the negedge of a start cycle: idle for dly wait cycles, then ack.
  task automatic mem_ack(input int dly, input logic [DW-1:0] data, input logic rdom);
    tick();
    repeat (dly) tick();
    ack = 1'b1; read_data = data; resp_domain = rdom;
    tick();
    ack = 1'b0; read_data = '0; resp_domain = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1; req_val = '1; req_op = '0; req_domain = '0;
    req_src_addr = '0; req_dest_addr = '0;
    ack = 1'b0; read_data = '0; resp_domain = 1'b0; result_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_result_val", 64'(result_val), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_result_data", 64'(result_data), 64'd0);
    chk("rst_result_err", 64'(result_err), 64'd0);
    chk("rst_result_ch", 64'(result_ch), 64'd0);
    chk("rst_domain", 64'(domain), 64'd0);
    chk("rst_src_addr", 64'(src_addr), 64'd0);
    chk("rst_dest_addr", 64'(dest_addr), 64'd0);
    tick();
    req_val = '0; reset = 1'b0;

    // COPY on channel 1: debug phase then extract from the destination
    st_q.push_back('{1'b0, 32'h100, 32'h200, 1'b0});
    st_q.push_back('{1'b1, 32'h200, 32'h200, 1'b0});
    rs_q.push_back('{2'd1, 32'hDEADBEEF, 1'b0});
    issue(1, COPY, 32'h100, 32'h200, 1'b0);
    wait_start("t1_dbg_start");
    mem_ack(3, 32'h0, 1'b0);
    wait_start("t1_ext_start");
    mem_ack(0, 32'hDEADBEEF, 1'b0);
    wait_result("t1_result", n);
    tick();

    // Domain filter: a foreign-domain ack is ignored
    st_q.push_back('{1'b1, 32'h300, 32'h400, 1'b1});
    rs_q.push_back('{2'd2, 32'hCAFE0002, 1'b0});
    issue(2, READ, 32'h300, 32'h400, 1'b1);
    wait_start("t2_ext_start");
    tick();
    ack = 1'b1; resp_domain = 1'b0; read_data = 32'h11111111;
    tick();
    ack = 1'b0; read_data = '0;
    tick();
    ack = 1'b1; resp_domain = 1'b1; read_data = 32'hCAFE0002;
    tick();
    ack = 1'b0; resp_domain = 1'b0; read_data = '0;
    wait_result("t2_result", n);
    tick();

    // Extract timeout: error result with zero data after 5 wait cycles
    st_q.push_back('{1'b1, 32'h500, 32'h600, 1'b0});
    rs_q.push_back('{2'd3, 32'h0, 1'b1});
    issue(3, READ, 32'h500, 32'h600, 1'b0);
    wait_start("t3_ext_start");
    read_data = 32'h12345678;
    wait_result("t3_result", n);
    chk("t3_wait_cycles", 64'(n), 64'd5);
    tick();
    read_data = '0;

    // Ack on the last allowed wait cycle wins over the timeout
    st_q.push_back('{1'b1, 32'h700, 32'h800, 1'b0});
    rs_q.push_back('{2'd0, 32'h0BADF00D, 1'b0});
    issue(0, READ, 32'h700, 32'h800, 1'b0);
    wait_start("t4_ext_start");
    mem_ack(4, 32'h0BADF00D, 1'b0);
    wait_result("t4_result", n);
    tick();

    // Debug-phase timeout: no extract phase, error result
    st_q.push_back('{1'b0, 32'h900, 32'hA00, 1'b1});
    rs_q.push_back('{2'd1, 32'h0, 1'b1});
    issue(1, COPY, 32'h900, 32'hA00, 1'b1);
    wait_start("t5_dbg_start");
    wait_result("t5_result", n);
    chk("t5_wait_cycles", 64'(n), 64'd5);
    tick();

    // Back-pressure: result held stable, no new grant while stalled
    result_rdy = 1'b0;
    st_q.push_back('{1'b1, 32'hB00, 32'hC00, 1'b0});
    rs_q.push_back('{2'd2, 32'h5A5A5A5A, 1'b0});
    issue(2, READ, 32'hB00, 32'hC00, 1'b0);
    wait_start("t6_ext_start");
    req_op[3] = READ; req_src_addr[3*AW +: AW] = 32'hD00;
    req_dest_addr[3*AW +: AW] = 32'hE00; req_domain[3] = 1'b0; req_val[3] = 1'b1;
    mem_ack(1, 32'h5A5A5A5A, 1'b0);
    wait_result("t6_result", n);
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold_val", 64'(result_val), 64'd1);
      chk("t6_hold_data", 64'(result_data), 64'h5A5A5A5A);
      chk("t6_hold_ch", 64'(result_ch), 64'd2);
      chk("t6_hold_err", 64'(result_err), 64'd0);
      chk("t6_hold_rdy", 64'(req_rdy), 64'd0);
      @(negedge clk);
    end
    gr_q.push_back(3);
    st_q.push_back('{1'b1, 32'hD00, 32'hE00, 1'b0});
    rs_q.push_back('{2'd3, 32'h33, 1'b0});
    tick();
    result_rdy = 1'b1;
    wait_start("t6b_ext_start");
    req_val = '0;
    mem_ack(0, 32'h33, 1'b0);
    wait_result("t6b_result", n);
    tick();

    // All channels requesting READ: grants rotate 0,1,2,3,0
    for (int c = 0; c < NCH; c++) begin
      req_op[c] = READ; req_domain[c] = 1'b0;
      req_src_addr[c*AW +: AW]  = 32'h1000 + 32'(c) * 32'h10;
      req_dest_addr[c*AW +: AW] = 32'h2000 + 32'(c);
    end
    for (int k = 0; k < 5; k++) begin
      gr_q.push_back(k % 4);
      st_q.push_back('{1'b1, 32'h1000 + 32'(k % 4) * 32'h10, 32'h2000 + 32'(k % 4), 1'b0});
      rs_q.push_back('{CW'(k % 4), 32'hA0 + 32'(k), 1'b0});
    end
    req_val = '1;
    for (int k = 0; k < 5; k++) begin
      wait_start("t7_ext_start");
      if (k == 4) req_val = '0;
      mem_ack(0, 32'hA0 + 32'(k), 1'b0);
      wait_result("t7_result", n);
      tick();
    end

    // Reset in the extract wait abandons the command and rewinds the arbiter
    st_q.push_back('{1'b1, 32'hE00, 32'hF00, 1'b0});
    issue(1, READ, 32'hE00, 32'hF00, 1'b0);
    wait_start("t8_ext_start");
    tick();
    tick();
    reset = 1'b1; req_val = 4'b0010;
    @(negedge clk);
    chk("t8_rst_start", 64'(start), 64'd0);
    chk("t8_rst_result_val", 64'(result_val), 64'd0);
    chk("t8_rst_req_rdy", 64'(req_rdy), 64'd0);
    req_op[0] = READ; req_src_addr[0 +: AW] = 32'h1234; req_dest_addr[0 +: AW] = 32'h4321;
    req_domain[0] = 1'b0;
    gr_q.push_back(0);
    st_q.push_back('{1'b1, 32'h1234, 32'h4321, 1'b0});
    rs_q.push_back('{2'd0, 32'h44, 1'b0});
    tick();
    reset = 1'b0; req_val = 4'b0101;
    @(negedge clk);
    chk("t8_post_start", 64'(start), 64'd0);
    chk("t8_post_result_val", 64'(result_val), 64'd0);
    chk("t8_post_req_rdy", 64'(req_rdy), 64'b0001);
    tick();
    req_val = '0;
    wait_start("t8b_ext_start");
    mem_ack(0, 32'h44, 1'b0);
    wait_result("t8b_result", n);
    tick();

    repeat (3) tick();
    chk("grants_drained", 64'(gr_q.size()), 64'd0);
    chk("starts_drained", 64'(st_q.size()), 64'd0);
    chk("results_drained", 64'(rs_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
